gpu_core_sequencer: RTL and testbench
=====================================

// Module: gpu_core_sequencer
// PURPOSE
//  Parametrised multi-cycle fetch/decode/execute sequencer for the shader core. Owns PC, the
//  fetched instruction and the run/halt control; drives the instruction RAM read port and
//  hands off to variable-latency execute and load/store units.
//  While halted, the host owns the instruction, data and register RAM ports.
// PARAMETERS
//  ADDRESS_WIDTH  16  byte-address width of PC and instruction space
//  RESET_PC       0   PC value loaded on reset
//  MEM_LATENCY    1   instruction RAM read latency in cycles (>=1)
// PORTS
//  clock              in   1   system clock
//  reset_n            in   1   asynchronous, active-low reset
//  run                in   1   level; leaves HALTED when high
//  halt_request       in   1   level; halt after the current instruction retires
//  inst_address       out  AW  byte address to instruction RAM
//  inst_data          in   32  instruction RAM read data
//  inst               out  32  latched instruction, feeds the decoder
//  inst_valid         out  1   high from DECODE through STEP
//  exec_start         out  1   one-cycle pulse on the first EXECUTE cycle
//  exec_done          in   1   execute unit finished; sampled only in EXECUTE
//  exec_is_mem        in   1   instruction is a load/store; sampled with exec_done
//  exec_branch_taken  in   1   use exec_target as next PC; sampled with exec_done
//  exec_target        in   AW  branch/jump target; sampled with exec_done
//  mem_req            out  1   load/store request; held until mem_ack
//  mem_ack            in   1   load/store complete; ignored while mem_req is low
//  retire             out  1   one-cycle pulse; the instruction just completed
//  pc                 out  AW  current PC
//  state              out  3   encoding: HALTED=0 FETCH_ADDR=1 FETCH_WAIT=2 DECODE=3 EXECUTE=4 MEMORY=5 STEP=6
//  halted             out  1   state==HALTED; host-access grant
//  halt_cause         out  2   0=reset 1=request 2=misaligned target 3=breakpoint
//  instret            out  32  retired-instruction counter, wraps at 2^32
// BEHAVIOUR
//  - Reset (async): state=HALTED, pc=RESET_PC, inst=0, instret=0, halt_cause=0.
//    All pulses/requests are 0; inst_address=RESET_PC.
//  - Reset mid-instruction aborts it: no retire, and mem_req drops immediately.
//  - HALTED: run=1 & halt_request=0 -> FETCH_ADDR. halt_request wins if both high.
//  - FETCH_ADDR: inst_address<=pc -> FETCH_WAIT.
//  - FETCH_WAIT: wait MEM_LATENCY cycles (down-counter), then inst<=inst_data -> DECODE.
//  - DECODE: one settle cycle -> EXECUTE.
//  - EXECUTE: exec_start=1 on the first cycle only. Stay until exec_done=1.
//    exec_done may be high in that first cycle. On exec_done, latch branch_taken/target.
//    Next state: exec_is_mem ? MEMORY : STEP.
//  - MEMORY: mem_req=1 until mem_ack; the cycle mem_ack is seen -> STEP, mem_req<=0.
//  - STEP: next = taken ? target : pc+4, computed mod 2^AW (pc+4 wraps to 0).
//    instret+=1; retire pulses in the following cycle.
//      - next[1:0]!=0: pc unchanged, halt_cause=2 -> HALTED (instruction still retires).
//      - else pc<=next; if halt_request: halt_cause=1 -> HALTED, else -> FETCH_ADDR.
//  - Minimum cycles per instruction = 4+MEM_LATENCY (exec_done in first cycle, no memory).
//  - halt_request is never sampled mid-instruction; run is ignored outside HALTED.
// CONFIGURATION
//  GPU_SEQ_BREAKPOINT_EN defined:
//    - adds ports bp_enable (in 1) and bp_address (in AW).
//    - In STEP, if bp_enable and next==bp_address (aligned): pc<=next, halt_cause=3 -> HALTED.
//    - Misaligned check takes priority over breakpoint; breakpoint over request.
//    - Resuming from a breakpoint executes the instruction at bp_address without re-halting:
//      a one-shot skip flag is set on leaving HALTED and cleared at the next STEP.
//  Undefined: no breakpoint ports or logic; halt_cause 3 is never produced.
// TESTING
//  1 Reset, run=1, exec_done tied 1, exec_is_mem=0, inst RAM of NOPs:
//    -> retire every 5 cycles; pc 0,4,8..; instret counts.
//  2 ADDRESS_WIDTH=8, start pc=0xFC:
//    -> next pc wraps to 0x00, no halt.
//  3 exec_is_mem=1, mem_ack delayed 3 cycles:
//    -> mem_req high exactly 3 cycles, retire 1 cycle after ack, 8 cycles/instr.
//  4 exec_branch_taken=1 with exec_target=0x0022:
//    -> halted, halt_cause=2, pc unchanged, instret+1.
//  5 halt_request raised mid-EXECUTE:
//    -> instruction retires, halted, halt_cause=1; run with halt_request high stays halted.
//  6 (GPU_SEQ_BREAKPOINT_EN) bp_address=0x10:
//    -> halt with pc=0x10, cause 3; run -> executes 0x10, next at 0x14.
//    Async reset asserted in MEMORY -> mem_req=0 at once, state HALTED.

Source files
------------

// File: rtl/gpu_core_sequencer.sv
// gpu_core_sequencer
//   Multi-cycle fetch/decode/execute sequencer for the shader core. It owns the PC,
//   the fetched instruction and run/halt control. It drives the instruction RAM read
//   port and hands each instruction to the variable-latency execute unit and, for
//   loads/stores, to the load/store unit. While halted, the host owns the RAM ports.
//
//   Optional feature: define GPU_SEQ_BREAKPOINT_EN to add a single PC breakpoint
//   (ports bp_enable, bp_address; halt_cause 3).
//
// Ports
//   clock, reset_n         clock and asynchronous active-low reset
//   run, halt_request      host control levels
//   inst_address/inst_data instruction RAM read port
//   inst, inst_valid       latched instruction for the decoder
//   exec_start/exec_done   execute-unit handshake (+ is_mem, branch_taken, target)
//   mem_req/mem_ack        load/store handshake
//   retire, instret        retirement pulse and counter
//   pc, state, halted      architectural PC, FSM state, host-access grant
//   halt_cause             0=reset 1=request 2=misaligned target 3=breakpoint
module gpu_core_sequencer #(
    parameter int                       ADDRESS_WIDTH = 16,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
    parameter int                       MEM_LATENCY   = 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     run,
    input  logic                     halt_request,
    output logic [ADDRESS_WIDTH-1:0] inst_address,
    input  logic [31:0]              inst_data,
    output logic [31:0]              inst,
    output logic                     inst_valid,
    output logic                     exec_start,
    input  logic                     exec_done,
    input  logic                     exec_is_mem,
    input  logic                     exec_branch_taken,
    input  logic [ADDRESS_WIDTH-1:0] exec_target,
    output logic                     mem_req,
    input  logic                     mem_ack,
    output logic                     retire,
    output logic [ADDRESS_WIDTH-1:0] pc,
    output logic [2:0]               state,
    output logic                     halted,
    output logic [1:0]               halt_cause,
`ifdef GPU_SEQ_BREAKPOINT_EN
    input  logic                     bp_enable,
    input  logic [ADDRESS_WIDTH-1:0] bp_address,
`endif
    output logic [31:0]              instret
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [2:0] {
        S_HALTED     = 3'd0,
        S_FETCH_ADDR = 3'd1,
        S_FETCH_WAIT = 3'd2,
        S_DECODE     = 3'd3,
        S_EXECUTE    = 3'd4,
        S_MEMORY     = 3'd5,
        S_STEP       = 3'd6
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] pc_q;
    logic [ADDRESS_WIDTH-1:0] inst_address_q;
    logic [31:0]              inst_q;
    logic [31:0]              instret_q;
    logic [1:0]               halt_cause_q;
    logic [CNT_W-1:0]         wait_cnt_q;
    logic                     exec_start_q;
    logic                     mem_req_q;
    logic                     retire_q;
    logic                     taken_q;
    logic [ADDRESS_WIDTH-1:0] target_q;

    logic [ADDRESS_WIDTH-1:0] step_next;
    logic                     step_misaligned;
    logic                     bp_hit;

`ifdef GPU_SEQ_BREAKPOINT_EN
    // Set when leaving HALTED so a resume does not re-trigger on the same
    // breakpoint; consumed by the first STEP afterwards.
    logic                     bp_skip_q;
`endif

    // Next-PC candidate, evaluated continuously but only acted on in STEP.
    always_comb begin
        step_next       = taken_q ? target_q : (pc_q + ADDRESS_WIDTH'(4));
        step_misaligned = (step_next[1:0] != 2'b00);
        bp_hit          = 1'b0;
`ifdef GPU_SEQ_BREAKPOINT_EN
        bp_hit          = bp_enable && !bp_skip_q && (step_next == bp_address);
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_HALTED;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HALTED:     if (run && !halt_request) state_d = S_FETCH_ADDR;
            S_FETCH_ADDR: state_d = S_FETCH_WAIT;
            S_FETCH_WAIT: if (wait_cnt_q == '0) state_d = S_DECODE;
            S_DECODE:     state_d = S_EXECUTE;
            S_EXECUTE:    if (exec_done) state_d = exec_is_mem ? S_MEMORY : S_STEP;
            S_MEMORY:     if (mem_req_q && mem_ack) state_d = S_STEP;
            S_STEP:       state_d = (step_misaligned || bp_hit || halt_request)
                                    ? S_HALTED : S_FETCH_ADDR;
            default:      state_d = S_HALTED;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q           <= RESET_PC;
            inst_address_q <= RESET_PC;
            inst_q         <= '0;
            instret_q      <= '0;
            halt_cause_q   <= 2'd0;
            wait_cnt_q     <= '0;
            exec_start_q   <= 1'b0;
            mem_req_q      <= 1'b0;
            retire_q       <= 1'b0;
            taken_q        <= 1'b0;
            target_q       <= '0;
`ifdef GPU_SEQ_BREAKPOINT_EN
            bp_skip_q      <= 1'b0;
`endif
        end else begin
            // Both pulses are one cycle long: exec_start marks the first EXECUTE
            // cycle, retire the cycle after STEP.
            exec_start_q <= (state_q == S_DECODE);
            retire_q     <= (state_q == S_STEP);
            case (state_q)
                S_HALTED: begin
`ifdef GPU_SEQ_BREAKPOINT_EN
                    if (run && !halt_request) bp_skip_q <= 1'b1;
`endif
                end
                S_FETCH_ADDR: begin
                    inst_address_q <= pc_q;
                    wait_cnt_q     <= CNT_W'(MEM_LATENCY - 1);
                end
                S_FETCH_WAIT: begin
                    if (wait_cnt_q == '0) inst_q     <= inst_data;
                    else                  wait_cnt_q <= wait_cnt_q - CNT_W'(1);
                end
                S_EXECUTE: begin
                    if (exec_done) begin
                        taken_q  <= exec_branch_taken;
                        target_q <= exec_target;
                        if (exec_is_mem) mem_req_q <= 1'b1;
                    end
                end
                S_MEMORY: begin
                    if (mem_ack) mem_req_q <= 1'b0;
                end
                S_STEP: begin
                    instret_q <= instret_q + 32'd1;
`ifdef GPU_SEQ_BREAKPOINT_EN
                    bp_skip_q <= 1'b0;
`endif
                    // A misaligned target keeps the old PC so the host can inspect
                    // the faulting instruction.
                    if (step_misaligned) begin
                        halt_cause_q <= 2'd2;
                    end else begin
                        pc_q <= step_next;
                        if (bp_hit)            halt_cause_q <= 2'd3;
                        else if (halt_request) halt_cause_q <= 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign inst_address = inst_address_q;
    assign inst         = inst_q;
    assign inst_valid   = (state_q == S_DECODE) || (state_q == S_EXECUTE) ||
                          (state_q == S_MEMORY) || (state_q == S_STEP);
    assign exec_start   = exec_start_q;
    assign mem_req      = mem_req_q;
    assign retire       = retire_q;
    assign pc           = pc_q;
    assign state        = state_q;
    assign halted       = (state_q == S_HALTED);
    assign halt_cause   = halt_cause_q;
    assign instret      = instret_q;

endmodule

// File: tb/tb_gpu_core_sequencer.sv
// Directed testbench for gpu_core_sequencer. A 16-bit instance covers the main
// scenarios; an 8-bit instance starting at 0xFC covers PC wrap-around.
module tb_gpu_core_sequencer;

    localparam logic [2:0] S_HALTED     = 3'd0;
    localparam logic [2:0] S_FETCH_ADDR = 3'd1;
    localparam logic [2:0] S_EXECUTE    = 3'd4;
    localparam logic [2:0] S_MEMORY     = 3'd5;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        run, halt_request;
    logic        exec_done, exec_is_mem, exec_branch_taken;
    logic [15:0] exec_target;
    logic        mem_ack;
    logic        bp_enable;
    logic [15:0] bp_address;

    logic [15:0] inst_address, pc;
    logic [31:0] inst_data, inst, instret;
    logic        inst_valid, exec_start, mem_req, retire, halted;
    logic [2:0]  state;
    logic [1:0]  halt_cause;

    logic [7:0]  inst_address_8, pc_8;
    logic [31:0] inst_data_8, inst_8, instret_8;
    logic        inst_valid_8, exec_start_8, mem_req_8, retire_8, halted_8;
    logic [2:0]  state_8;
    logic [1:0]  halt_cause_8;

    int checks   = 0;
    int failures = 0;
    bit ack_en   = 1'b1;

    always #5 clock = ~clock;

    // Instruction RAM model: each word encodes its own address.
    assign inst_data   = {16'hA5A5, inst_address};
    assign inst_data_8 = {24'h0, inst_address_8};

    gpu_core_sequencer #(.ADDRESS_WIDTH(16), .RESET_PC(16'h0000), .MEM_LATENCY(1)) dut (
        .clock(clock), .reset_n(reset_n), .run(run), .halt_request(halt_request),
        .inst_address(inst_address), .inst_data(inst_data), .inst(inst),
        .inst_valid(inst_valid), .exec_start(exec_start), .exec_done(exec_done),
        .exec_is_mem(exec_is_mem), .exec_branch_taken(exec_branch_taken),
        .exec_target(exec_target), .mem_req(mem_req), .mem_ack(mem_ack),
        .retire(retire), .pc(pc), .state(state), .halted(halted),
        .halt_cause(halt_cause),
`ifdef GPU_SEQ_BREAKPOINT_EN
        .bp_enable(bp_enable), .bp_address(bp_address),
`endif
        .instret(instret)
    );

    gpu_core_sequencer #(.ADDRESS_WIDTH(8), .RESET_PC(8'hFC), .MEM_LATENCY(1)) dut8 (
        .clock(clock), .reset_n(reset_n), .run(run), .halt_request(halt_request),
        .inst_address(inst_address_8), .inst_data(inst_data_8), .inst(inst_8),
        .inst_valid(inst_valid_8), .exec_start(exec_start_8), .exec_done(exec_done),
        .exec_is_mem(exec_is_mem), .exec_branch_taken(exec_branch_taken),
        .exec_target(exec_target[7:0]), .mem_req(mem_req_8), .mem_ack(mem_ack),
        .retire(retire_8), .pc(pc_8), .state(state_8), .halted(halted_8),
        .halt_cause(halt_cause_8),
`ifdef GPU_SEQ_BREAKPOINT_EN
        .bp_enable(1'b0), .bp_address(8'h00),
`endif
        .instret(instret_8)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        run = 0; halt_request = 0; exec_done = 1; exec_is_mem = 0;
        exec_branch_taken = 0; exec_target = 16'h0; mem_ack = 0;
        bp_enable = 0; bp_address = 16'h0; ack_en = 1;
        reset_n = 0;
        tick(); tick();
        reset_n = 1;
        tick();
    endtask

    // Advance until retire is seen, acting as the load/store unit (ack on the
    // third mem_req cycle) and collecting per-instruction counts.
    task automatic wait_retire(input int budget, output int cyc, output int mreq,
                               output int inval, output int estart, output int gap,
                               output bit ok);
        bit prev_req;
        int fall_i, req_cnt;
        cyc = 0; mreq = 0; inval = 0; estart = 0; gap = -1; ok = 0;
        prev_req = mem_req; fall_i = 0; req_cnt = 0;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (mem_req) begin mreq++; req_cnt++; end else req_cnt = 0;
            if (inst_valid) inval++;
            if (exec_start) estart++;
            if (prev_req && !mem_req) fall_i = i;
            prev_req = mem_req;
            mem_ack = ack_en && mem_req && (req_cnt >= 3);
            if (retire) begin cyc = i; gap = i - fall_i; ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (state !== S_HALTED || halted !== 1'b1) begin failures++;
            $display("FAIL reset_state got state=%0d halted=%0b want 0/1", state, halted); end
        checks++; if (pc !== 16'h0 || inst_address !== 16'h0) begin failures++;
            $display("FAIL reset_pc got pc=%h addr=%h want 0000/0000", pc, inst_address); end
        checks++; if (inst !== 32'h0 || instret !== 32'h0 || halt_cause !== 2'd0) begin failures++;
            $display("FAIL reset_regs got inst=%h instret=%0d cause=%0d want 0/0/0", inst, instret, halt_cause); end
        checks++; if (mem_req !== 0 || retire !== 0 || exec_start !== 0 || inst_valid !== 0) begin failures++;
            $display("FAIL reset_pulses got req=%0b ret=%0b es=%0b iv=%0b want 0", mem_req, retire, exec_start, inst_valid); end
        tick(); tick();
        checks++; if (state !== S_HALTED) begin failures++;
            $display("FAIL idle_halted got state=%0d want 0", state); end
    endtask

    task automatic test_nop_stream();
        int cyc, mreq, inval, estart, gap; bit ok;
        do_reset();
        run = 1;
        wait_retire(20, cyc, mreq, inval, estart, gap, ok);
        checks++; if (!ok) begin failures++; $display("FAIL nop_timeout1 got no retire want retire"); end
        checks++; if (pc !== 16'h0004 || instret !== 32'd1 || inst !== 32'hA5A5_0000) begin failures++;
            $display("FAIL nop_first got pc=%h instret=%0d inst=%h want 0004/1/a5a50000", pc, instret, inst); end
        wait_retire(20, cyc, mreq, inval, estart, gap, ok);
        checks++; if (!ok || cyc !== 5) begin failures++;
            $display("FAIL nop_period got %0d want 5", cyc); end
        checks++; if (pc !== 16'h0008 || instret !== 32'd2 || inst !== 32'hA5A5_0004) begin failures++;
            $display("FAIL nop_second got pc=%h instret=%0d inst=%h want 0008/2/a5a50004", pc, instret, inst); end
        checks++; if (inval !== 3 || estart !== 1) begin failures++;
            $display("FAIL nop_pulses got inst_valid=%0d exec_start=%0d want 3/1", inval, estart); end
        wait_retire(20, cyc, mreq, inval, estart, gap, ok);
        checks++; if (!ok || cyc !== 5 || pc !== 16'h000C || instret !== 32'd3) begin failures++;
            $display("FAIL nop_third got cyc=%0d pc=%h instret=%0d want 5/000c/3", cyc, pc, instret); end
        run = 0;
    endtask

    task automatic test_pc_wrap();
        int cyc, mreq, inval, estart, gap; bit ok;
        do_reset();
        checks++; if (pc_8 !== 8'hFC) begin failures++;
            $display("FAIL wrap_reset_pc got %h want fc", pc_8); end
        run = 1;
        wait_retire(20, cyc, mreq, inval, estart, gap, ok);
        checks++; if (!ok || retire_8 !== 1'b1) begin failures++;
            $display("FAIL wrap_retire got ok=%0b retire=%0b want 1/1", ok, retire_8); end
        checks++; if (pc_8 !== 8'h00 || halted_8 !== 1'b0 || state_8 !== S_FETCH_ADDR || instret_8 !== 32'd1) begin failures++;
            $display("FAIL wrap_pc got pc=%h halted=%0b state=%0d instret=%0d want 00/0/1/1", pc_8, halted_8, state_8, instret_8); end
        wait_retire(20, cyc, mreq, inval, estart, gap, ok);
        checks++; if (pc_8 !== 8'h04 || inst_8 !== 32'h0000_0000) begin failures++;
            $display("FAIL wrap_next got pc=%h inst=%h want 04/00000000", pc_8, inst_8); end
        run = 0;
    endtask

    task automatic test_memory();
        int cyc, mreq, inval, estart, gap; bit ok;
        do_reset();
        exec_is_mem = 1;
        run = 1;
        wait_retire(30, cyc, mreq, inval, estart, gap, ok);
        checks++; if (!ok || mreq !== 3) begin failures++;
            $display("FAIL mem_first got ok=%0b req_cycles=%0d want 1/3", ok, mreq); end
        wait_retire(30, cyc, mreq, inval, estart, gap, ok);
        checks++; if (!ok || cyc !== 8) begin failures++;
            $display("FAIL mem_period got %0d want 8", cyc); end
        checks++; if (mreq !== 3 || gap !== 1) begin failures++;
            $display("FAIL mem_handshake got req_cycles=%0d ack_to_retire=%0d want 3/1", mreq, gap); end
        checks++; if (pc !== 16'h0008 || instret !== 32'd2 || mem_req !== 1'b0) begin failures++;
            $display("FAIL mem_state got pc=%h instret=%0d req=%0b want 0008/2/0", pc, instret, mem_req); end
        run = 0;
    endtask

    task automatic test_misaligned();
        int cyc, mreq, inval, estart, gap; bit ok;
        do_reset();
        exec_branch_taken = 1;
        exec_target = 16'h0022;
        run = 1;
        wait_retire(20, cyc, mreq, inval, estart, gap, ok);
        run = 0;
        checks++; if (!ok || state !== S_HALTED || halted !== 1'b1 || halt_cause !== 2'd2) begin failures++;
            $display("FAIL misaligned_halt got state=%0d cause=%0d want 0/2", state, halt_cause); end
        checks++; if (pc !== 16'h0000 || instret !== 32'd1) begin failures++;
            $display("FAIL misaligned_pc got pc=%h instret=%0d want 0000/1", pc, instret); end
    endtask

    task automatic test_halt_request();
        int cyc, mreq, inval, estart, gap; bit ok;
        do_reset();
        exec_done = 0;
        run = 1;
        for (int i = 0; i < 20 && state !== S_EXECUTE; i++) tick();
        checks++; if (state !== S_EXECUTE) begin failures++;
            $display("FAIL halt_reach_exec got state=%0d want 4", state); end
        halt_request = 1;
        tick(); tick(); tick();
        checks++; if (state !== S_EXECUTE || exec_start !== 1'b0) begin failures++;
            $display("FAIL halt_exec_wait got state=%0d es=%0b want 4/0", state, exec_start); end
        exec_done = 1;
        wait_retire(20, cyc, mreq, inval, estart, gap, ok);
        checks++; if (!ok || state !== S_HALTED || halt_cause !== 2'd1) begin failures++;
            $display("FAIL halt_request got state=%0d cause=%0d want 0/1", state, halt_cause); end
        checks++; if (pc !== 16'h0004 || instret !== 32'd1) begin failures++;
            $display("FAIL halt_pc got pc=%h instret=%0d want 0004/1", pc, instret); end
        tick(); tick(); tick();
        checks++; if (state !== S_HALTED || halted !== 1'b1) begin failures++;
            $display("FAIL halt_stays got state=%0d want 0", state); end
        halt_request = 0;
        tick();
        checks++; if (state !== S_FETCH_ADDR) begin failures++;
            $display("FAIL halt_resume got state=%0d want 1", state); end
        tick();
        checks++; if (inst_address !== 16'h0004) begin failures++;
            $display("FAIL halt_resume_addr got %h want 0004", inst_address); end
        run = 0;
    endtask

`ifdef GPU_SEQ_BREAKPOINT_EN
    task automatic test_breakpoint();
        int cyc, mreq, inval, estart, gap; bit ok;
        do_reset();
        bp_enable = 1;
        bp_address = 16'h0010;
        run = 1;
        for (int n = 0; n < 4; n++) wait_retire(20, cyc, mreq, inval, estart, gap, ok);
        checks++; if (!ok || state !== S_HALTED || halt_cause !== 2'd3 || pc !== 16'h0010) begin failures++;
            $display("FAIL bp_halt got state=%0d cause=%0d pc=%h want 0/3/0010", state, halt_cause, pc); end
        wait_retire(20, cyc, mreq, inval, estart, gap, ok);
        checks++; if (!ok || pc !== 16'h0014 || state !== S_FETCH_ADDR || instret !== 32'd5) begin failures++;
            $display("FAIL bp_resume got pc=%h state=%0d instret=%0d want 0014/1/5", pc, state, instret); end
        run = 0;
    endtask
`endif

    task automatic test_reset_in_memory();
        do_reset();
        exec_is_mem = 1;
        ack_en = 0;
        run = 1;
        for (int i = 0; i < 20 && state !== S_MEMORY; i++) tick();
        checks++; if (state !== S_MEMORY || mem_req !== 1'b1) begin failures++;
            $display("FAIL rst_mem_reach got state=%0d req=%0b want 5/1", state, mem_req); end
        #2;
        reset_n = 0;
        #1;
        checks++; if (mem_req !== 1'b0 || state !== S_HALTED || retire !== 1'b0 || instret !== 32'd0) begin failures++;
            $display("FAIL rst_mem_abort got req=%0b state=%0d ret=%0b instret=%0d want 0/0/0/0", mem_req, state, retire, instret); end
        run = 0;
        tick();
        reset_n = 1;
        tick();
        ack_en = 1;
    endtask

    initial begin
        test_reset();
        test_nop_stream();
        test_pc_wrap();
        test_memory();
        test_misaligned();
        test_halt_request();
`ifdef GPU_SEQ_BREAKPOINT_EN
        test_breakpoint();
`endif
        test_reset_in_memory();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
